// File: rtl/de2_70_nios2_processor_div_cell.sv
// Iterative radix-2 restoring divider serving Nios II div/divu in the A stage.
// A start strobe accepted while idle launches one division. The result appears
// WIDTH+1 cycles later, flagged by a one-cycle done pulse, and is then held
// until the next done.
//
// Ports:
//   clk              clock, rising edge
//   reset_n          asynchronous active-low reset
//   A_div_start      one-cycle request, sampled only while A_div_busy is low
//   A_div_signed     1 = signed div, 0 = divu (sampled with start)
//   A_div_src1       dividend (sampled with start)
//   A_div_src2       divisor (sampled with start)
//   A_div_busy       high while a division is in flight
//   A_div_done       one-cycle pulse when quotient/remainder update
//   A_div_quotient   quotient, held until the next done
//   A_div_remainder  remainder, held until the next done
module de2_70_nios2_processor_div_cell #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             A_div_start,
   input  logic             A_div_signed,
   input  logic [WIDTH-1:0] A_div_src1,
   input  logic [WIDTH-1:0] A_div_src2,
   output logic             A_div_busy,
   output logic             A_div_done,
   output logic [WIDTH-1:0] A_div_quotient,
   output logic [WIDTH-1:0] A_div_remainder
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
   logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, becomes quotient
   logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
   logic [WIDTH-1:0] src1_q, src1_d;   // original dividend for divide-by-zero
   logic             neg_quot_q, neg_quot_d;
   logic             neg_rem_q, neg_rem_d;
   logic             dz_q, dz_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] remd_q, remd_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             qbit;
   logic             src1_neg;
   logic             src2_neg;

   // One restoring step. Because the partial remainder is always below the
   // divisor, a set top bit of trial can only come from a borrow.
   assign shifted = {rem_q, dvd_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs_q};
   assign qbit    = ~trial[WIDTH];

   assign src1_neg = A_div_signed & A_div_src1[WIDTH-1];
   assign src2_neg = A_div_signed & A_div_src2[WIDTH-1];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      src1_d     = src1_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      dz_d       = dz_q;
      done_d     = 1'b0;
      quot_d     = quot_q;
      remd_d     = remd_q;

      unique case (state_q)
         StIdle: begin
            if (A_div_start) begin
               neg_quot_d = src1_neg ^ src2_neg;
               neg_rem_d  = src1_neg;
               dz_d       = (A_div_src2 == '0);
               src1_d     = A_div_src1;
               // abs of the most negative value wraps to itself, which is the
               // correct magnitude when read as unsigned.
               dvd_d      = src1_neg ? -A_div_src1 : A_div_src1;
               dvs_d      = src2_neg ? -A_div_src2 : A_div_src2;
               rem_d      = '0;
               cnt_d      = '0;
               state_d    = StCalc;
            end
         end
         StCalc: begin
            rem_d = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], qbit};
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            done_d  = 1'b1;
            state_d = StIdle;
            if (dz_q) begin
               quot_d = '1;
               remd_d = src1_q;
            end else begin
               quot_d = neg_quot_q ? -dvd_q : dvd_q;
               remd_d = neg_rem_q ? -rem_q : rem_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         rem_q      <= '0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         src1_q     <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         dz_q       <= 1'b0;
         done_q     <= 1'b0;
         quot_q     <= '0;
         remd_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         src1_q     <= src1_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         dz_q       <= dz_d;
         done_q     <= done_d;
         quot_q     <= quot_d;
         remd_q     <= remd_d;
      end
   end

   assign A_div_busy      = (state_q != StIdle);
   assign A_div_done      = done_q;
   assign A_div_quotient  = quot_q;
   assign A_div_remainder = remd_q;

endmodule

// File: tb/tb_de2_70_nios2_processor_div_cell.sv
// Scoreboard bench for the Nios II divide cell: the driver pushes the expected
// result and done cycle on each accepted start; a negedge monitor checks busy,
// held outputs, and every done against the queue.
module tb_de2_70_nios2_processor_div_cell;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        sgn = 1'b0;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic        busy;
   logic        done;
   logic [31:0] quot;
   logic [31:0] remd;

   de2_70_nios2_processor_div_cell #(.WIDTH(32)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .A_div_start     (start),
      .A_div_signed    (sgn),
      .A_div_src1      (src1),
      .A_div_src2      (src2),
      .A_div_busy      (busy),
      .A_div_done      (done),
      .A_div_quotient  (quot),
      .A_div_remainder (remd)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic [31:0] a;
      logic [31:0] b;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          busy_from = 1;
   int          busy_to = 0;
   logic [31:0] held_q = '0;
   logic [31:0] held_r = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on 64-bit values; truncation
   // towards zero matches div/divu, and the overflow case wraps naturally.
   task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r);
      longint sa;
      longint sb2;
      if (b == 0) begin
         q = '1;
         r = a;
      end else if (s) begin
         sa  = longint'($signed(a));
         sb2 = longint'($signed(b));
         q   = 32'(sa / sb2);
         r   = 32'(sa % sb2);
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic busy_exp;
      if (reset_n) begin
         busy_exp = (cyc >= busy_from) && (cyc <= busy_to);
         chk("busy", {31'b0, busy}, {31'b0, busy_exp});
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_done cyc=%0d got=1 exp=0", cyc);
            end else begin
               e = sb.pop_front();
               chk("done_cycle", 32'(cyc), 32'(e.cyc));
               chk("quotient", quot, e.q);
               chk("remainder", remd, e.r);
               if (e.b != 0) chk("invariant", quot * e.b + remd, e.a);
               held_q = e.q;
               held_r = e.r;
            end
         end else begin
            chk("held_quotient", quot, held_q);
            chk("held_remainder", remd, held_r);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge with the DUT idle.
   task automatic issue_exp(input logic s, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eq, input logic [31:0] er);
      exp_t e;
      if (busy !== 1'b0) begin
         checks++;
         failures++;
         $display("FAIL issue_not_idle cyc=%0d got=%b exp=0", cyc, busy);
      end
      sgn   = s;
      src1  = a;
      src2  = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      // Scramble operands: they must not matter once accepted.
      sgn   = $urandom_range(0, 1);
      src1  = $urandom;
      src2  = $urandom;
      e.q   = eq;
      e.r   = er;
      e.a   = a;
      e.b   = b;
      e.cyc = cyc + 33;
      busy_from = cyc;
      busy_to   = cyc + 32;
      sb.push_back(e);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      if (done !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL done_timeout cyc=%0d got=0 exp=1", cyc);
      end
   endtask

   task automatic run_exp(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er);
      issue_exp(s, a, b, eq, er);
      wait_done();
   endtask

   task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      ref_div(s, a, b, q, r);
      run_exp(s, a, b, q, r);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 9))
         0:       v = 32'h0;
         1:       v = 32'h1;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'h8000_0000;
         4:       v = 32'($urandom_range(0, 20));
         5:       v = -32'($urandom_range(1, 20));
         6:       v = $urandom >> $urandom_range(0, 31);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      #1;
      chk("reset_busy", {31'b0, busy}, 32'h0);
      chk("reset_done", {31'b0, done}, 32'h0);
      chk("reset_quotient", quot, 32'h0);
      chk("reset_remainder", remd, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();

      run_exp(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
      run_exp(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
      run_exp(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
      run_exp(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
      run_exp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
      run_exp(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
      run_exp(1'b0, 32'd5, 32'd9, 32'd0, 32'd5);
      run_exp(1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234);
      run_exp(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
      run_exp(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

      // Start pulsed mid-operation with other operands must be ignored.
      issue_exp(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);
      repeat (5) tick();
      sgn   = 1'b1;
      src1  = 32'd77;
      src2  = 32'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done();

      // Back-to-back: next start issued in the done cycle.
      run_exp(1'b0, 32'd81, 32'd9, 32'd9, 32'd0);
      run_exp(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);

      // Reset abort after ten cycles of an operation.
      issue_exp(1'b0, 32'd999, 32'd4, 32'd249, 32'd3);
      repeat (9) tick();
      reset_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'h0);
      chk("abort_done", {31'b0, done}, 32'h0);
      chk("abort_quotient", quot, 32'h0);
      chk("abort_remainder", remd, 32'h0);
      sb.delete();
      busy_from = 1;
      busy_to   = 0;
      held_q    = '0;
      held_r    = '0;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (40) tick();
      run_exp(1'b0, 32'd50, 32'd5, 32'd10, 32'd0);

      for (int i = 0; i < 1500; i++) begin
         run(1'($urandom_range(0, 1)), pick(), pick());
      end

      repeat (3) tick();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
